mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single-ported instruction/data memory between two requesters: the fetch stage (read-only instruction port) and the load/store stage (read/write data port).
- Sits between both stages and the memory model.
- Serialises requests with one outstanding transaction at a time, using two-way round-robin priority.
- Discards the response of an in-flight instruction read when fetch is flushed.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data/instruction width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req_valid  in  1  fetch read request; held until i_rsp_ready
- i_req_addr  in  ADDR_W  fetch read address
- i_rsp_data  out  DATA_W  instruction returned
- i_rsp_ready  out  1  one-cycle pulse, i_rsp_data valid
- i_flush  in  1  fetch flush; abandons the in-flight fetch response
- d_req_valid  in  1  data request; held until d_rsp_ready
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  byte enables for writes
- d_rsp_data  out  DATA_W  load data (0 on writes)
- d_rsp_ready  out  1  one-cycle pulse, access complete
- mem_enable  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes access in the current cycle

## Operation
- State machine: IDLE, MEM, RESP, DRAIN. Owner register: I or D. last_owner register: I or D.
- **IDLE**
  - Any valid request: grant it and latch addr/we/wdata/wstrb into mem_* registers; go to MEM.
  - Both valid: grant the requester that is not last_owner.
  - last_owner resets to I, so D wins the first tie.
- **MEM**
  - mem_enable = 1; mem_* are held stable.
  - On mem_ready = 1: capture mem_rdata into the owner's rsp_data register and go to RESP.
  - i_flush = 1 with owner I: go to DRAIN.
- **DRAIN**
  - mem_enable stays 1 until mem_ready.
  - Then go to IDLE: no i_rsp_ready pulse, i_rsp_data unchanged.
  - i_flush repeated here: no effect.
- **RESP**
  - Owner's rsp_ready = 1 for exactly one cycle; mem_enable = 0.
  - last_owner <= owner; go to IDLE.
  - No grant is made in RESP, so the requester can drop or renew valid.
- i_flush in IDLE or RESP: no effect. Fetch itself drops i_req_valid.
- i_flush with owner D: no effect on the data transaction.
- Write responses: d_rsp_data = 0.
- mem_we / mem_wstrb are forced to 0 for I-owned accesses.

## Timing
- **Reset values**: state IDLE, last_owner I, all outputs 0 (mem_enable, mem_we, mem_addr, mem_wdata, mem_wstrb, both rsp_data, both rsp_ready).
- **Reset mid-transaction**: the transaction is abandoned; mem_enable = 0 on the cycle after the reset edge. The memory model tolerates this.
- **Latency** (request valid sampled at edge 0):
  - mem_enable rises after edge 0.
  - mem_ready sampled at edge k; rsp_ready high during cycle k+1.
  - Minimum: 2 cycles from request to response, 3 cycles between back-to-back grants (IDLE→MEM→RESP).
- **Memory stall**: mem_ready low for N cycles extends MEM/DRAIN by N cycles. No timeout.
- **Change of request under a pending grant**: a requester changing addr while valid and not yet granted is legal; the address is latched at the grant edge.
- **Flush and completion on the same edge** (i_flush = 1 and mem_ready = 1): flush wins, go to IDLE with no pulse.
- **Starvation bound**: with both requesters continuously valid, grants alternate D, I, D, I. Neither waits more than one transaction.

## Structure
- State encodings (IDLE/MEM/RESP/DRAIN) and owner encoding (OWN_I = 0, OWN_D = 1) go in the shared params.v alongside ADDR/INSTR sizes.
- One sub-module: mem_arb_pick, the combinational 2-way round-robin picker (inputs: two valids, last_owner; outputs: grant, owner).
- Everything else lives in mem_arbiter.

## Test plan
- **Single fetch**: i_req_valid with addr 0x100, memory returns 0x00500093 with mem_ready on the first MEM cycle → i_rsp_ready pulses 1 cycle, 2 cycles after the request, with i_rsp_data = 0x00500093. No d_rsp_ready.
- **Contention after reset**: both valid at cycle 0 (I addr 0x0, D read 0x200) → D served first, then I. After 4 back-to-back pairs, the grant order is D, I, D, I, D, I, D, I.
- **Store**: d_req_we = 1, addr 0x300, wdata 0xDEADBEEF, wstrb 0b0011 → mem_we = 1, mem_wstrb = 0b0011 during MEM; d_rsp_ready pulse with d_rsp_data = 0.
- **Flush in flight**: I granted, mem_ready held low 3 cycles, i_flush pulsed in the 2nd → mem_enable stays high until mem_ready, no i_rsp_ready ever. A pending D request is granted in the cycle after the drain completes.
- **Flush coincident with mem_ready**: no i_rsp_ready; state returns to IDLE.
- **Reset mid-MEM**: reset asserted while D access stalled → next cycle all outputs 0 and state IDLE. A subsequent I request completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states,
// owner identifiers and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not own the last completed transaction wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_valid,
    input  logic   d_valid,
    input  owner_e last_owner,
    output logic   grant,
    output owner_e owner
);

    always_comb begin
        grant = i_valid | d_valid;
        owner = OWN_I;
        if (i_valid && d_valid) begin
            if (last_owner == OWN_I) owner = OWN_D;
            else                     owner = OWN_I;
        end else if (d_valid) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one single-ported memory,
// one transaction at a time, and drops fetch responses abandoned by a flush.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic [DATA_W-1:0]   i_rsp_data,
    output logic                i_rsp_ready,
    input  logic                i_flush,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                d_rsp_ready,
    output logic                mem_enable,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   i_rsp_data_q, i_rsp_data_d;
    logic [DATA_W-1:0]   d_rsp_data_q, d_rsp_data_d;

    logic   pick_grant;
    owner_e pick_owner;

    mem_arb_pick u_pick (
        .i_valid    (i_req_valid),
        .d_valid    (d_req_valid),
        .last_owner (last_owner_q),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        i_rsp_data_d = i_rsp_data_q;
        d_rsp_data_d = d_rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    state_d = ST_MEM;
                    owner_d = pick_owner;
                    if (pick_owner == OWN_D) begin
                        mem_we_d    = d_req_we;
                        mem_addr_d  = d_req_addr;
                        mem_wdata_d = d_req_wdata;
                        mem_wstrb_d = d_req_wstrb;
                    end else begin
                        // Fetch is read-only: never let it write.
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_req_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            ST_MEM: begin
                if (owner_q == OWN_I && i_flush) begin
                    // A flush wins over a same-edge completion; the data is discarded.
                    state_d = mem_ready ? ST_IDLE : ST_DRAIN;
                end else if (mem_ready) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_I) i_rsp_data_d = mem_rdata;
                    else                  d_rsp_data_d = mem_we_q ? '0 : mem_rdata;
                end
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            i_rsp_data_q <= '0;
            d_rsp_data_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            i_rsp_data_q <= i_rsp_data_d;
            d_rsp_data_q <= d_rsp_data_d;
        end
    end

    assign mem_enable  = (state_q == ST_MEM) || (state_q == ST_DRAIN);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign i_rsp_data  = i_rsp_data_q;
    assign d_rsp_data  = d_rsp_data_q;
    assign i_rsp_ready = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign d_rsp_ready = (state_q == ST_RESP) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenario bench for mem_arbiter; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic [31:0] i_rsp_data;
    logic        i_rsp_ready;
    logic        i_flush;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_rsp_data;
    logic        d_rsp_ready;
    logic        mem_enable;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_i_data;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_ready (i_rsp_ready),
        .i_flush     (i_flush),
        .d_req_valid (d_req_valid),
        .d_req_we    (d_req_we),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_req_wstrb (d_req_wstrb),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_ready (d_rsp_ready),
        .mem_enable  (mem_enable),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req_valid = 0; i_req_addr = 0; i_flush = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wstrb = 0;
        mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        n_cmp++; if ({mem_enable, mem_we, i_rsp_ready, d_rsp_ready} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {mem_enable, mem_we, i_rsp_ready, d_rsp_ready}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_err++; $display("FAIL reset_membus: got %h want 0", {mem_addr, mem_wdata, mem_wstrb}); end
        n_cmp++; if ({i_rsp_data, d_rsp_data} !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", {i_rsp_data, d_rsp_data}); end
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        i_req_valid = 1; i_req_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h0050_0093;
        tick();
        n_cmp++; if ({mem_enable, mem_we, i_rsp_ready} !== 3'b100) begin n_err++; $display("FAIL fetch_grant_flags: got %b want 100", {mem_enable, mem_we, i_rsp_ready}); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
        tick();
        n_cmp++; if ({i_rsp_ready, d_rsp_ready, mem_enable} !== 3'b100) begin n_err++; $display("FAIL fetch_rsp_flags: got %b want 100", {i_rsp_ready, d_rsp_ready, mem_enable}); end
        n_cmp++; if (i_rsp_data !== 32'h0050_0093) begin n_err++; $display("FAIL fetch_rsp_data: got %h want 00500093", i_rsp_data); end
        i_req_valid = 0; mem_ready = 0;
        tick();
        n_cmp++; if ({i_rsp_ready, d_rsp_ready} !== 2'b00) begin n_err++; $display("FAIL fetch_pulse_width: got %b want 00", {i_rsp_ready, d_rsp_ready}); end
    endtask

    task automatic test_contention();
        logic [7:0] order;
        int         n_rsp;
        do_reset();
        order = '0; n_rsp = 0;
        i_req_valid = 1; i_req_addr = 32'h0;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h200;
        mem_ready = 1; mem_rdata = 32'h0000_1234;
        tick();
        n_cmp++; if (mem_addr !== 32'h200) begin n_err++; $display("FAIL tie_first_addr: got %h want 00000200", mem_addr); end
        for (int c = 0; c < 23; c++) begin
            tick();
            if (i_rsp_ready && d_rsp_ready) begin
                n_cmp++; n_err++; $display("FAIL tie_dual_pulse: got both ready at cycle %0d want one", c);
            end
            if ((i_rsp_ready || d_rsp_ready) && n_rsp < 8) begin
                order[n_rsp] = d_rsp_ready;
                n_rsp++;
            end
        end
        // order[k] = 1 when the k-th response went to D: expect D,I,D,I,...
        n_cmp++; if (n_rsp !== 8) begin n_err++; $display("FAIL tie_count: got %0d want 8", n_rsp); end
        n_cmp++; if (order !== 8'b0101_0101) begin n_err++; $display("FAIL tie_order: got %b want 01010101", order); end
        n_cmp++; if ({i_rsp_data, d_rsp_data} !== {32'h1234, 32'h1234}) begin n_err++; $display("FAIL tie_rsp_data: got %h want 0000123400001234", {i_rsp_data, d_rsp_data}); end
        i_req_valid = 0; d_req_valid = 0; mem_ready = 0;
        tick();
        exp_i_data = 32'h0000_1234;
    endtask

    task automatic test_store();
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h300; d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'b0011;
        mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        n_cmp++; if ({mem_enable, mem_we, mem_wstrb} !== 6'b11_0011) begin n_err++; $display("FAIL store_ctrl: got %b want 110011", {mem_enable, mem_we, mem_wstrb}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== {32'h300, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL store_bus: got %h want 00000300deadbeef", {mem_addr, mem_wdata}); end
        mem_ready = 1;
        tick();
        n_cmp++; if ({d_rsp_ready, i_rsp_ready} !== 2'b10) begin n_err++; $display("FAIL store_rsp_flags: got %b want 10", {d_rsp_ready, i_rsp_ready}); end
        n_cmp++; if (d_rsp_data !== 32'h0) begin n_err++; $display("FAIL store_rsp_data: got %h want 00000000", d_rsp_data); end
        d_req_valid = 0; d_req_we = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_flush_inflight();
        logic saw_i_pulse;
        saw_i_pulse = 0;
        // last owner is D after the store, so I wins this tie.
        i_req_valid = 1; i_req_addr = 32'h400;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h500;
        mem_ready = 0;
        tick();
        n_cmp++; if ({mem_enable, mem_addr} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL flush_grant: got %h want 100000400", {mem_enable, mem_addr}); end
        tick(); saw_i_pulse |= i_rsp_ready;
        i_flush = 1;
        tick(); saw_i_pulse |= i_rsp_ready;
        i_flush = 0; i_req_valid = 0;
        n_cmp++; if (mem_enable !== 1'b1) begin n_err++; $display("FAIL flush_drain_en: got %b want 1", mem_enable); end
        tick(); saw_i_pulse |= i_rsp_ready;
        n_cmp++; if ({mem_enable, mem_addr} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL flush_drain_hold: got %h want 100000400", {mem_enable, mem_addr}); end
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        tick(); saw_i_pulse |= i_rsp_ready;
        mem_ready = 0;
        n_cmp++; if (mem_enable !== 1'b0) begin n_err++; $display("FAIL flush_drain_done: got %b want 0", mem_enable); end
        n_cmp++; if (i_rsp_data !== exp_i_data) begin n_err++; $display("FAIL flush_data_kept: got %h want %h", i_rsp_data, exp_i_data); end
        tick(); saw_i_pulse |= i_rsp_ready;
        n_cmp++; if ({mem_enable, mem_we, mem_addr} !== {2'b10, 32'h500}) begin n_err++; $display("FAIL flush_d_grant: got %h want 200000500", {mem_enable, mem_we, mem_addr}); end
        mem_ready = 1; mem_rdata = 32'h0A0B_0C0D;
        tick(); saw_i_pulse |= i_rsp_ready;
        n_cmp++; if ({d_rsp_ready, d_rsp_data} !== {1'b1, 32'h0A0B_0C0D}) begin n_err++; $display("FAIL flush_d_rsp: got %h want 10a0b0c0d", {d_rsp_ready, d_rsp_data}); end
        d_req_valid = 0; mem_ready = 0;
        tick(); saw_i_pulse |= i_rsp_ready;
        n_cmp++; if (saw_i_pulse !== 1'b0) begin n_err++; $display("FAIL flush_no_i_pulse: got %b want 0", saw_i_pulse); end
    endtask

    task automatic test_flush_coincident();
        i_req_valid = 1; i_req_addr = 32'h600; mem_ready = 0;
        tick();
        i_flush = 1; mem_ready = 1; mem_rdata = 32'h7777_8888; i_req_valid = 0;
        tick();
        n_cmp++; if ({i_rsp_ready, mem_enable} !== 2'b00) begin n_err++; $display("FAIL coinc_flags: got %b want 00", {i_rsp_ready, mem_enable}); end
        n_cmp++; if (i_rsp_data !== exp_i_data) begin n_err++; $display("FAIL coinc_data_kept: got %h want %h", i_rsp_data, exp_i_data); end
        i_flush = 0; mem_ready = 0;
        tick();
        n_cmp++; if (i_rsp_ready !== 1'b0) begin n_err++; $display("FAIL coinc_late_pulse: got %b want 0", i_rsp_ready); end
        i_req_valid = 1; i_req_addr = 32'h700; mem_ready = 1; mem_rdata = 32'h1111_2222;
        tick();
        n_cmp++; if ({mem_enable, mem_addr} !== {1'b1, 32'h700}) begin n_err++; $display("FAIL coinc_regrant: got %h want 100000700", {mem_enable, mem_addr}); end
        tick();
        n_cmp++; if ({i_rsp_ready, i_rsp_data} !== {1'b1, 32'h1111_2222}) begin n_err++; $display("FAIL coinc_next_rsp: got %h want 111112222", {i_rsp_ready, i_rsp_data}); end
        i_req_valid = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid_mem();
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h800; mem_ready = 0;
        tick();
        tick();
        n_cmp++; if ({mem_enable, mem_addr} !== {1'b1, 32'h800}) begin n_err++; $display("FAIL rst_mid_stall: got %h want 100000800", {mem_enable, mem_addr}); end
        reset = 1; d_req_valid = 0;
        tick();
        reset = 0;
        n_cmp++; if ({mem_enable, mem_we, i_rsp_ready, d_rsp_ready} !== 4'b0) begin n_err++; $display("FAIL rst_mid_flags: got %b want 0000", {mem_enable, mem_we, i_rsp_ready, d_rsp_ready}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb, i_rsp_data, d_rsp_data} !== 132'h0) begin n_err++; $display("FAIL rst_mid_regs: got %h want 0", {mem_addr, mem_wdata, mem_wstrb, i_rsp_data, d_rsp_data}); end
        i_req_valid = 1; i_req_addr = 32'h900; mem_ready = 1; mem_rdata = 32'h3333_4444;
        tick();
        n_cmp++; if ({mem_enable, mem_addr} !== {1'b1, 32'h900}) begin n_err++; $display("FAIL rst_mid_regrant: got %h want 100000900", {mem_enable, mem_addr}); end
        tick();
        n_cmp++; if ({i_rsp_ready, i_rsp_data} !== {1'b1, 32'h3333_4444}) begin n_err++; $display("FAIL rst_mid_rsp: got %h want 133334444", {i_rsp_ready, i_rsp_data}); end
        i_req_valid = 0; mem_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_flush_inflight();
        test_flush_coincident();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
